// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Optional status flags on the TX FIFO are enabled with the macro UART_FIFO_STATUS_EN.
package uart_pkg;

  localparam int UART_DW            = 8;
  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_TX_FIFO_AW    = 4;

  // What the FIFO does on a given clock edge, after accept/reject decisions.
  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_PUSH = 2'b01,
    FIFO_OP_POP  = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// DEPTH x DW storage: one synchronous write port and one asynchronous read port.
// The array has no reset; its contents are only meaningful behind the pointers.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DW    = UART_DW,
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int AW    = UART_TX_FIFO_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding uart_tx. Head byte is visible on rd_data while
// empty=0. Optional sticky ovf/udf flags with clr_sts when UART_FIFO_STATUS_EN
// is defined; otherwise rejected pushes/pops are silently dropped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DW    = UART_DW,
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int AW    = UART_TX_FIFO_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   level
`ifdef UART_FIFO_STATUS_EN
  ,
  input  logic          clr_sts,
  output logic          ovf,
  output logic          udf
`endif
);

  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          push_s;
  logic          pop_s;
  fifo_op_e      op_s;

  // A push while full is still taken when a pop frees the head slot the same edge.
  assign push_s = wr_en & (~full_q | rd_en);
  assign pop_s  = rd_en & ~empty_q;

  // Classify the edge and compute next pointers, occupancy and status.
  always_comb begin
    op_s     = FIFO_OP_IDLE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    case ({pop_s, push_s})
      2'b01:   op_s = FIFO_OP_PUSH;
      2'b10:   op_s = FIFO_OP_POP;
      2'b11:   op_s = FIFO_OP_BOTH;
      default: op_s = FIFO_OP_IDLE;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (op_s)
      FIFO_OP_PUSH: level_d = level_q + LVL_ONE;
      FIFO_OP_POP:  level_d = level_q - LVL_ONE;
      FIFO_OP_BOTH: level_d = level_q;
      default:      level_d = level_q;
    endcase
  end

  // full/empty come from the next level so they are flops, not decodes of wr_en/rd_en.
  assign full_d  = (level_d == LVL_DEPTH);
  assign empty_d = (level_d == LVL_ZERO);

  // Pointer, occupancy and status registers; reset discards all contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  uart_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

`ifdef UART_FIFO_STATUS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (wr_en & ~push_s) begin
      ovf_d = 1'b1;
    end else if (clr_sts) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (rd_en & empty_q) begin
      udf_d = 1'b1;
    end else if (clr_sts) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Status flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule : uart_tx_fifo
